// File: rtl/sr_latch_enable.sv
// sr_latch_enable: clocked SR storage with per-lane level enable.
// Q is registered; Qbar is derived combinationally from the same register so the two can never agree.
`default_nettype none

module sr_latch_enable #(
  parameter int   WIDTH     = 1,
  parameter logic RESET_Q   = 1'b0,
  parameter int   BOTH_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] EN,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      logic both_val;

      // Conflict resolution for S=R=1: clear, set, or keep the present value.
      assign both_val = (BOTH_MODE == 1) ? 1'b1 :
                        (BOTH_MODE == 2) ? q_q[i] : 1'b0;

      assign q_d[i] = !EN[i]          ? q_q[i]   :
                      (S[i] && R[i])  ? both_val :
                      S[i]            ? 1'b1     :
                      R[i]            ? 1'b0     : q_q[i];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= {WIDTH{RESET_Q}};
    end else begin
      q_q <= q_d;
    end
  end

  assign Q    = q_q;
  assign Qbar = ~q_q;

endmodule

`default_nettype wire

// File: tb/tb_sr_latch_enable.sv
// Scoreboard bench for sr_latch_enable: five builds share one stimulus stream
// (default, set-wins, hold, reset-to-one, 4-lane) and are checked one edge later.
`default_nettype none

module tb_sr_latch_enable;

  logic       clk;
  logic       rst;
  logic [3:0] R, S, EN;

  logic       q0, qb0, q1, qb1, q2, qb2, q3, qb3;
  logic [3:0] q4, qb4;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic       e0, e1, e2, e3;
    logic [3:0] e4;
  } exp_t;

  exp_t exp_q[$];
  logic       m0, m1, m2, m3;
  logic [3:0] m4;

  sr_latch_enable #(.WIDTH(1), .RESET_Q(1'b0), .BOTH_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .R(R[0]), .S(S[0]), .EN(EN[0]), .Q(q0), .Qbar(qb0));
  sr_latch_enable #(.WIDTH(1), .RESET_Q(1'b0), .BOTH_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .R(R[0]), .S(S[0]), .EN(EN[0]), .Q(q1), .Qbar(qb1));
  sr_latch_enable #(.WIDTH(1), .RESET_Q(1'b0), .BOTH_MODE(2)) dut2 (
    .clk(clk), .rst(rst), .R(R[0]), .S(S[0]), .EN(EN[0]), .Q(q2), .Qbar(qb2));
  sr_latch_enable #(.WIDTH(1), .RESET_Q(1'b1), .BOTH_MODE(0)) dut3 (
    .clk(clk), .rst(rst), .R(R[0]), .S(S[0]), .EN(EN[0]), .Q(q3), .Qbar(qb3));
  sr_latch_enable #(.WIDTH(4), .RESET_Q(1'b0), .BOTH_MODE(0)) dut4 (
    .clk(clk), .rst(rst), .R(R), .S(S), .EN(EN), .Q(q4), .Qbar(qb4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  // Reference behaviour of a bank of lanes over one clock edge.
  function automatic logic [3:0] model(input logic [3:0] q, input logic rs,
                                       input logic [3:0] en, input logic [3:0] s,
                                       input logic [3:0] r, input logic rq,
                                       input int mode);
    logic [3:0] n;
    for (int i = 0; i < 4; i++) begin
      if (rs)                  n[i] = rq;
      else if (!en[i])         n[i] = q[i];
      else if (s[i] && r[i])   n[i] = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : q[i];
      else if (s[i])           n[i] = 1'b1;
      else if (r[i])           n[i] = 1'b0;
      else                     n[i] = q[i];
    end
    return n;
  endfunction

  task automatic push_exp(input string tag);
    exp_t e;
    logic [3:0] t;
    t  = model({3'b0, m0}, rst, EN, S, R, 1'b0, 0); m0 = t[0];
    t  = model({3'b0, m1}, rst, EN, S, R, 1'b0, 1); m1 = t[0];
    t  = model({3'b0, m2}, rst, EN, S, R, 1'b0, 2); m2 = t[0];
    t  = model({3'b0, m3}, rst, EN, S, R, 1'b1, 0); m3 = t[0];
    m4 = model(m4, rst, EN, S, R, 1'b0, 0);
    e.tag = tag; e.e0 = m0; e.e1 = m1; e.e2 = m2; e.e3 = m3; e.e4 = m4;
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 4'd1, 4'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({e.tag, "/d0.q"},  {3'b0, q0},  {3'b0, e.e0});
    chk({e.tag, "/d0.qb"}, {3'b0, qb0}, {3'b0, ~e.e0});
    chk({e.tag, "/d1.q"},  {3'b0, q1},  {3'b0, e.e1});
    chk({e.tag, "/d2.q"},  {3'b0, q2},  {3'b0, e.e2});
    chk({e.tag, "/d3.q"},  {3'b0, q3},  {3'b0, e.e3});
    chk({e.tag, "/d3.qb"}, {3'b0, qb3}, {3'b0, ~e.e3});
    chk({e.tag, "/d4.q"},  q4,          e.e4);
    chk({e.tag, "/d4.qb"}, qb4,         ~e.e4);
  endtask

  task automatic step(input string tag, input logic rs, input logic [3:0] en,
                      input logic [3:0] s, input logic [3:0] r);
    rst = rs; EN = en; S = s; R = r;
    push_exp(tag);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    rst = 1'b0; R = '0; S = '0; EN = '0;
    m0 = 1'bx; m1 = 1'bx; m2 = 1'bx; m3 = 1'bx; m4 = 'x;
    @(negedge clk);

    // Reset, then hold with enable low.
    step("reset",      1'b1, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) step("hold_en0", 1'b0, 4'h0, 4'h0, 4'h0);

    // Set requested while disabled, then enabled.
    step("set_dis", 1'b0, 4'h0, 4'hF, 4'h0);
    step("set_dis", 1'b0, 4'h0, 4'hF, 4'h0);
    step("set_en",  1'b0, 4'hF, 4'hF, 4'h0);

    // Clear requested while disabled, then enabled, then idle.
    step("clr_dis",  1'b0, 4'h0, 4'h0, 4'hF);
    step("clr_en",   1'b0, 4'hF, 4'h0, 4'hF);
    step("idle_en",  1'b0, 4'hF, 4'h0, 4'h0);

    // Simultaneous S and R from Q=0, then from Q=1.
    step("both_q0",  1'b0, 4'hF, 4'hF, 4'hF);
    step("reset",    1'b1, 4'h0, 4'h0, 4'h0);
    step("set_en",   1'b0, 4'hF, 4'hF, 4'h0);
    step("both_q1",  1'b0, 4'hF, 4'hF, 4'hF);

    // Reset overrides a concurrent set.
    step("set_en",     1'b0, 4'hF, 4'hF, 4'h0);
    step("rst_vs_set", 1'b1, 4'hF, 4'hF, 4'h0);

    // Per-lane enable masking.
    step("lane_mask",  1'b0, 4'b0101, 4'hF, 4'h0);
    step("lane_clr",   1'b0, 4'b0100, 4'h0, 4'hF);

    // A set pulse that ends before the edge must be ignored.
    step("reset", 1'b1, 4'h0, 4'h0, 4'h0);
    rst = 1'b0; EN = 4'h0; S = 4'h0; R = 4'h0;
    push_exp("glitch");
    EN = 4'hF; S = 4'hF;
    #3;
    EN = 4'h0; S = 4'h0;
    @(posedge clk);
    #1;
    pop_check();

    // Random traffic with occasional reset.
    for (int i = 0; i < 40; i++) begin
      step("rand", ($urandom_range(0, 9) == 0),
           4'($urandom), 4'($urandom), 4'($urandom));
    end

    chk("scoreboard_drained", 4'(exp_q.size()), 4'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
